hv_wdg_rsp_ctrl: RTL and testbench

HV_WDG_RSP_CTRL -- requirements
Module: hv_wdg_rsp_ctrl

---
 rtl/hv_wdg_rsp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hv_wdg_rsp_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_wdg_rsp_ctrl.sv
// -----------------------------------------------------------------------------
// hv_wdg_rsp_ctrl
//   HV-side watchdog responder. A valid watchdog frame from the LV side, meaning
//   a received frame with no CRC error while enabled, does three things:
//     - It refreshes the timeout counter.
//     - It clears the timeout error.
//     - It clears the consecutive-timeout count.
//   If no response is in flight, the frame also starts an RSP_DLY-cycle
//   turnaround. After the turnaround, a level request is raised to the OWT
//   transmitter until the transmitter acks it.
//   If the LV side stays silent for TMO_TH[cfg] cycles, a timeout is flagged.
//   ERR_CNT_TH back-to-back timeouts latch a sticky fatal error.
//
// Ports
//   i_clk                 rising-edge clock
//   i_rst_n               synchronous active-low reset
//   i_wdg_en              block enable; low for one cycle clears everything
//   i_owt_rx_wdg_req      1-cycle pulse: watchdog frame received
//   i_owt_rx_crc_err      qualifies i_owt_rx_wdg_req: frame has a CRC error
//   i_wdgtmo_config[1:0]  timeout threshold select (TMO_TH0..TMO_TH3)
//   o_wdg_owt_tx_rsp_req  level: ask OWT TX to send the watchdog response
//   i_owt_tx_wdg_rsp_ack  1-cycle pulse: OWT TX accepted the response
//   o_wdg_timeout_err     LV side did not refresh within the threshold
//   o_wdg_fatal_err       sticky: ERR_CNT_TH consecutive timeouts
//   o_wdg_rsp_drop        1-cycle pulse: valid frame while response pending
// -----------------------------------------------------------------------------
module hv_wdg_rsp_ctrl #(
  parameter int WDG_CNT_W  = 16,
  parameter int RSP_DLY    = 8,
  parameter int TMO_TH0    = 1000,
  parameter int TMO_TH1    = 2000,
  parameter int TMO_TH2    = 4000,
  parameter int TMO_TH3    = 8000,
  parameter int ERR_CNT_TH = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wdg_en,
  input  logic       i_owt_rx_wdg_req,
  input  logic       i_owt_rx_crc_err,
  input  logic [1:0] i_wdgtmo_config,
  output logic       o_wdg_owt_tx_rsp_req,
  input  logic       i_owt_tx_wdg_rsp_ack,
  output logic       o_wdg_timeout_err,
  output logic       o_wdg_fatal_err,
  output logic       o_wdg_rsp_drop
);

  localparam int DLY_W = (RSP_DLY > 1) ? $clog2(RSP_DLY) : 1;
  localparam int ERR_W = $clog2(ERR_CNT_TH + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RSP_DLY - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(ERR_CNT_TH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DLY_W-1:0]       r_dly_cnt;
  logic [DLY_W-1:0]       w_dly_cnt_nxt;
  logic [WDG_CNT_W-1:0]   r_tmo_cnt;
  logic [WDG_CNT_W-1:0]   w_tmo_last;
  logic [ERR_W-1:0]       r_err_cnt;
  logic                   r_rsp_req;
  logic                   r_tmo_err;
  logic                   r_fatal;
  logic                   r_drop;
  logic                   w_frame;
  logic                   w_tmo_evt;
  logic                   w_busy;

  assign w_frame = i_wdg_en & i_owt_rx_wdg_req & ~i_owt_rx_crc_err;
  assign w_busy  = (r_state != IDLE);

  // Threshold is re-selected every cycle. A count already past a newly
  // lowered threshold just runs on and wraps at the counter width.
  always_comb begin
    w_tmo_last = WDG_CNT_W'(TMO_TH0 - 1);
    case (i_wdgtmo_config)
      2'd1:    w_tmo_last = WDG_CNT_W'(TMO_TH1 - 1);
      2'd2:    w_tmo_last = WDG_CNT_W'(TMO_TH2 - 1);
      2'd3:    w_tmo_last = WDG_CNT_W'(TMO_TH3 - 1);
      default: w_tmo_last = WDG_CNT_W'(TMO_TH0 - 1);
    endcase
  end

  // A frame in the same cycle as the threshold hit takes priority: no event.
  assign w_tmo_evt = i_wdg_en & ~w_frame & (r_tmo_cnt == w_tmo_last);

  // ---------------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_dly_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dly_cnt <= w_dly_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dly_cnt_nxt = r_dly_cnt;
    case (r_state)
      IDLE: begin
        if (w_frame) begin
          w_state_nxt   = DLY;
          w_dly_cnt_nxt = '0;
        end
      end
      DLY: begin
        if (r_dly_cnt == DLY_LAST) w_state_nxt = REQ;
        else                       w_dly_cnt_nxt = r_dly_cnt + DLY_W'(1);
      end
      REQ: begin
        if (i_owt_tx_wdg_rsp_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!i_wdg_en) begin
      w_state_nxt   = IDLE;
      w_dly_cnt_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and timeout tracking
  // ---------------------------------------------------------------------------
  // The request is a registered copy of "state is REQ". It therefore rises
  // one edge after the FSM enters REQ. A frame sampled at edge N raises the
  // request after edge N+RSP_DLY+1. The request also drops one edge after
  // the ack is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_wdg_en) begin
      r_tmo_cnt <= '0;
      r_err_cnt <= '0;
      r_rsp_req <= 1'b0;
      r_tmo_err <= 1'b0;
      r_fatal   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_rsp_req <= (r_state == REQ);
      r_drop    <= w_frame & w_busy;

      if (w_frame || w_tmo_evt) r_tmo_cnt <= '0;
      else                      r_tmo_cnt <= r_tmo_cnt + WDG_CNT_W'(1);

      if (w_frame)        r_tmo_err <= 1'b0;
      else if (w_tmo_evt) r_tmo_err <= 1'b1;

      if (w_frame)
        r_err_cnt <= '0;
      else if (w_tmo_evt && (r_err_cnt != ERR_MAX))
        r_err_cnt <= r_err_cnt + ERR_W'(1);

      // Sticky: only reset or disable clears it.
      r_fatal <= r_fatal | (r_err_cnt == ERR_MAX);
    end
  end

  assign o_wdg_owt_tx_rsp_req = r_rsp_req;
  assign o_wdg_timeout_err    = r_tmo_err;
  assign o_wdg_fatal_err      = r_fatal;
  assign o_wdg_rsp_drop       = r_drop;

endmodule

// File: tb/tb_hv_wdg_rsp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hv_wdg_rsp_ctrl
//   The bench first runs directed scenarios, then randomized traffic. A
//   behavioural model tracks the watchdog from timestamps and plain counts:
//     - the edge at which the in-flight response was accepted;
//     - cycles since the last refresh;
//     - consecutive timeouts.
//   Every edge is numbered. The model and the DUT both sample inputs at the
//   rising edge. Outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_hv_wdg_rsp_ctrl;

  localparam int RSP_DLY    = 8;
  localparam int ERR_CNT_TH = 3;
  localparam int CNT_W      = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req;
  logic       crc;
  logic [1:0] cfg;
  logic       ack;
  logic       rsp_req;
  logic       tmo_err;
  logic       fatal;
  logic       drop;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  hv_wdg_rsp_ctrl #(
    .WDG_CNT_W (CNT_W),
    .RSP_DLY   (RSP_DLY),
    .TMO_TH0   (1000),
    .TMO_TH1   (2000),
    .TMO_TH2   (4000),
    .TMO_TH3   (8000),
    .ERR_CNT_TH(ERR_CNT_TH)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_wdg_en            (en),
    .i_owt_rx_wdg_req    (req),
    .i_owt_rx_crc_err    (crc),
    .i_wdgtmo_config     (cfg),
    .o_wdg_owt_tx_rsp_req(rsp_req),
    .i_owt_tx_wdg_rsp_ack(ack),
    .o_wdg_timeout_err   (tmo_err),
    .o_wdg_fatal_err     (fatal),
    .o_wdg_rsp_drop      (drop)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int cyc   = 0;   // index of the rising edge just processed
  bit pend  = 0;   // a response has been accepted and not yet acked
  int start = 0;   // edge at which that response's frame was sampled
  int tmo   = 0;   // cycles since last refresh or wrap
  int cons  = 0;   // consecutive timeouts (saturating)
  bit m_req = 0, m_err = 0, m_fatal = 0, m_drop = 0;

  function automatic int th_of(input logic [1:0] c);
    case (c)
      2'd1:    return 2000;
      2'd2:    return 4000;
      2'd3:    return 8000;
      default: return 1000;
    endcase
  endfunction

  task automatic model_step();
    bit v;
    bit pend_b;
    bit in_req;
    cyc++;
    if (!rst_n || !en) begin
      pend = 0; tmo = 0; cons = 0;
      m_req = 0; m_err = 0; m_fatal = 0; m_drop = 0;
      return;
    end
    v      = req && !crc;
    pend_b = pend;
    // The turnaround covers edges start+1..start+RSP_DLY. Later edges are
    // in the request phase, where an ack is honoured.
    in_req = pend_b && (cyc > start + RSP_DLY);
    m_req  = in_req;
    m_drop = v && pend_b;
    if (in_req && ack) pend = 0;
    if (v && !pend_b) begin pend = 1; start = cyc; end
    m_fatal = m_fatal || (cons == ERR_CNT_TH);
    if (v) begin
      tmo = 0; m_err = 0; cons = 0;
    end else if (tmo == th_of(cfg) - 1) begin
      tmo = 0; m_err = 1;
      if (cons < ERR_CNT_TH) cons++;
    end else begin
      tmo = (tmo + 1) % (1 << CNT_W);
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rsp_req", rsp_req, m_req);
      check("timeout_err", tmo_err, m_err);
      check("fatal_err", fatal, m_fatal);
      check("rsp_drop", drop, m_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each returns just after the falling edge that follows
  // the last rising edge it drove.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input bit c);
    req = 1; crc = c; tick(); req = 0; crc = 0;
  endtask

  task automatic ack_pulse();
    ack = 1; tick(); ack = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios with hand-computed literal expectations, then random
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 0; en = 1; req = 0; crc = 0; cfg = 2'd0; ack = 0;
    tick(3);
    cmp_en = 1;
    check("reset_req", rsp_req, 1'b0);
    check("reset_err", tmo_err, 1'b0);
    check("reset_fatal", fatal, 1'b0);
    check("reset_drop", drop, 1'b0);
    rst_n = 1;
    tick(2);

    // Latency: frame sampled at edge F gives the request after edge F+9.
    frame(0);
    tick(8);  check("lat_pre", rsp_req, 1'b0);
    tick(1);  check("lat_on", rsp_req, 1'b1);
    tick(5);
    ack_pulse(); check("ack_hold", rsp_req, 1'b1);
    tick(1);     check("ack_off", rsp_req, 1'b0);
    tick(3);

    // Drop: a second frame during the turnaround pulses drop for one cycle.
    frame(0);                       // edge F
    tick(3);
    frame(0);                       // edge F+4
    check("drop_pulse", drop, 1'b1);
    tick(1); check("drop_end", drop, 1'b0);
    tick(4); check("drop_rsp", rsp_req, 1'b1);   // edge F+9
    ack_pulse(); tick(1);
    tick(20); check("single_rsp", rsp_req, 1'b0);

    // CRC-error frame: no response, no refresh. Timeout counts from edge F.
    frame(0);                       // edge F
    tick(10); ack_pulse();          // edge F+11
    tick(488);
    frame(1);                       // edge F+500, CRC error
    tick(10); check("crc_no_rsp", rsp_req, 1'b0);
    tick(489); check("tmo_pre", tmo_err, 1'b0);  // edge F+999
    tick(1);   check("tmo_set", tmo_err, 1'b1);  // edge F+1000
    tick(199);
    frame(0);                       // edge F+1200
    check("tmo_clr", tmo_err, 1'b0);
    tick(10); ack_pulse();

    // Collision: frame on the same edge as the threshold hit.
    frame(0);                       // edge H
    tick(10); ack_pulse();          // edge H+11
    tick(988);
    frame(0);                       // edge H+1000
    check("collide", tmo_err, 1'b0);
    tick(1); check("collide_next", tmo_err, 1'b0);
    tick(9); ack_pulse();

    // Fatal: three timeouts at K+1000/2000/3000; fatal follows one edge later.
    frame(0);                       // edge K
    tick(10); ack_pulse();          // edge K+11
    tick(2989);                     // edge K+3000
    check("fatal_pre", fatal, 1'b0);
    check("fatal_tmo", tmo_err, 1'b1);
    tick(1); check("fatal_set", fatal, 1'b1);
    frame(0);
    check("fatal_sticky", fatal, 1'b1);
    check("fatal_err_clr", tmo_err, 1'b0);
    tick(10); ack_pulse();
    en = 0; tick(1); check("fatal_en_clr", fatal, 1'b0);
    en = 1; tick(2);

    // Abort by disable.
    frame(0);
    tick(9); check("abort_pre", rsp_req, 1'b1);
    en = 0; tick(1); check("abort_en", rsp_req, 1'b0);
    en = 1; tick(30); check("abort_none", rsp_req, 1'b0);

    // Abort by reset.
    frame(0);
    tick(9); check("abortr_pre", rsp_req, 1'b1);
    rst_n = 0; tick(1); check("abort_rst", rsp_req, 1'b0);
    rst_n = 1; tick(30); check("abortr_none", rsp_req, 1'b0);

    // Random traffic. The first half is busy, for drops and responses. The
    // second half is sparse, for timeouts.
    for (int i = 0; i < 8000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 299) != 0);
      if (i < 4000) req = ($urandom_range(0, 39) == 0);
      else          req = ($urandom_range(0, 1499) == 0);
      crc   = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 999) == 0) cfg = 2'($urandom_range(0, 1));
      tick(1);
    end
    rst_n = 1; en = 1; req = 0; crc = 0; ack = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
